// File: rtl/wave_gen.sv
// Multi-channel periodic waveform generator: shared prescaler and phase counter,
// per-channel double-buffered mode/offset config, registered per-channel samples.
module wave_gen #(
  parameter int OUT_W   = 8,
  parameter int PRESC_W = 18,
  parameter int N_CH    = 4,
  localparam int PH_W   = OUT_W + 1,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PRESC_W-1:0]     div,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [PH_W-1:0]        cfg_offset,
  input  logic                   cfg_apply,
  output logic [N_CH*OUT_W-1:0]  value,
  output logic                   wrap
);

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  logic [PRESC_W-1:0]           presc_q, presc_d;
  logic [PH_W-1:0]              ph_q, ph_d;
  logic                         wrap_q, wrap_d;
  logic [N_CH-1:0][1:0]         pend_mode_q, pend_mode_d;
  logic [N_CH-1:0][PH_W-1:0]    pend_off_q, pend_off_d;
  logic [N_CH-1:0][1:0]         act_mode_q, act_mode_d;
  logic [N_CH-1:0][PH_W-1:0]    act_off_q, act_off_d;
  logic [N_CH*OUT_W-1:0]        value_q, value_d;
  logic [N_CH-1:0][PH_W-1:0]    ph_sum;
  logic                         tick;
  logic                         commit;

  // >= rather than == so a div lowered below the running count ticks at once
  always_comb begin
    tick    = en && (presc_q >= div);
    presc_d = presc_q;
    ph_d    = ph_q;
    if (tick) begin
      presc_d = '0;
      ph_d    = ph_q + PH_W'(1);
    end else if (en) begin
      presc_d = presc_q + PRESC_W'(1);
    end
    wrap_d = tick && (&ph_q);
    commit = cfg_apply || wrap_d;
  end

  // Commit copies the pending regs as they stand before this edge's write
  always_comb begin
    pend_mode_d = pend_mode_q;
    pend_off_d  = pend_off_q;
    act_mode_d  = act_mode_q;
    act_off_d   = act_off_q;
    for (int c = 0; c < N_CH; c++) begin
      if (commit) begin
        act_mode_d[c] = pend_mode_q[c];
        act_off_d[c]  = pend_off_q[c];
      end
      if (cfg_we && (cfg_ch == CH_W'(c))) begin
        pend_mode_d[c] = cfg_mode;
        pend_off_d[c]  = cfg_offset;
      end
    end
  end

  always_comb begin
    ph_sum  = '0;
    value_d = value_q;
    for (int c = 0; c < N_CH; c++) begin
      ph_sum[c] = ph_q + act_off_q[c];
      case (mode_e'(act_mode_q[c]))
        MODE_TRI: begin
          if (ph_sum[c][PH_W-1]) value_d[c*OUT_W +: OUT_W] = ~ph_sum[c][OUT_W-1:0];
          else                   value_d[c*OUT_W +: OUT_W] =  ph_sum[c][OUT_W-1:0];
        end
        MODE_SAW:    value_d[c*OUT_W +: OUT_W] = ph_sum[c][OUT_W-1:0];
        MODE_SQUARE: value_d[c*OUT_W +: OUT_W] = {OUT_W{ph_sum[c][PH_W-1]}};
        default:     value_d[c*OUT_W +: OUT_W] = value_q[c*OUT_W +: OUT_W];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      ph_q        <= '0;
      wrap_q      <= 1'b0;
      pend_mode_q <= '0;
      pend_off_q  <= '0;
      act_mode_q  <= '0;
      act_off_q   <= '0;
      value_q     <= '0;
    end else begin
      presc_q     <= presc_d;
      ph_q        <= ph_d;
      wrap_q      <= wrap_d;
      pend_mode_q <= pend_mode_d;
      pend_off_q  <= pend_off_d;
      act_mode_q  <= act_mode_d;
      act_off_q   <= act_off_d;
      value_q     <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_wave_gen.sv
// Randomized bench for wave_gen (OUT_W=8, PRESC_W=4, N_CH=2) against a cycle-level
// behavioural model built from integer phase arithmetic.
module tb_wave_gen;

   localparam int OUT_W   = 8;
   localparam int PRESC_W = 4;
   localparam int N_CH    = 2;
   localparam int PH_N    = 512;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  en;
   logic [PRESC_W-1:0]    div;
   logic                  cfg_we;
   logic [0:0]            cfg_ch;
   logic [1:0]            cfg_mode;
   logic [8:0]            cfg_offset;
   logic                  cfg_apply;
   logic [N_CH*OUT_W-1:0] value;
   logic                  wrap;

   int vectorCount = 0;
   int missCount   = 0;

   // Model state: integer phase/prescaler plus pending and active config per channel
   int mPresc, mPh, mWrap;
   int mPendMode [N_CH];
   int mPendOff  [N_CH];
   int mActMode  [N_CH];
   int mActOff   [N_CH];
   int mVal      [N_CH];
   int curDiv;

   wave_gen #(.OUT_W(OUT_W), .PRESC_W(PRESC_W), .N_CH(N_CH)) dut (
      .clk(clk), .rst(rst), .en(en), .div(div),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_offset(cfg_offset), .cfg_apply(cfg_apply),
      .value(value), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      vectorCount++;
      if (got != exp) begin
         missCount++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   // Ideal waveform for one channel at absolute phase p (0..511)
   function automatic int waveOf(input int mode, input int p, input int prev);
      case (mode)
         0:       return (p < 256) ? p : (511 - p);
         1:       return p % 256;
         2:       return (p >= 256) ? 255 : 0;
         default: return prev;
      endcase
   endfunction

   // Drive one cycle of inputs, advance the model across the coming edge, then check
   task automatic applyStimulus(input bit r, input bit e, input int d, input bit we,
                                input int ch, input int md, input int off, input bit ap);
      int tick;
      rst        = r;
      en         = e;
      div        = PRESC_W'(d);
      cfg_we     = we;
      cfg_ch     = 1'(ch);
      cfg_mode   = 2'(md);
      cfg_offset = 9'(off);
      cfg_apply  = ap;
      if (r) begin
         mPresc = 0; mPh = 0; mWrap = 0;
         for (int c = 0; c < N_CH; c++) begin
            mPendMode[c] = 0; mPendOff[c] = 0; mActMode[c] = 0; mActOff[c] = 0; mVal[c] = 0;
         end
      end else begin
         tick = (e && mPresc >= d) ? 1 : 0;
         for (int c = 0; c < N_CH; c++)
            mVal[c] = waveOf(mActMode[c], (mPh + mActOff[c]) % PH_N, mVal[c]);
         mWrap = (tick == 1 && mPh == PH_N - 1) ? 1 : 0;
         if (ap || mWrap == 1)
            for (int c = 0; c < N_CH; c++) begin
               mActMode[c] = mPendMode[c];
               mActOff[c]  = mPendOff[c];
            end
         if (we && ch < N_CH) begin
            mPendMode[ch] = md;
            mPendOff[ch]  = off;
         end
         if (tick == 1) begin
            mPresc = 0;
            mPh    = (mPh + 1) % PH_N;
         end else if (e) begin
            mPresc = mPresc + 1;
         end
      end
      @(negedge clk);
      checkOutput("value0", int'(value[7:0]),  mVal[0]);
      checkOutput("value1", int'(value[15:8]), mVal[1]);
      checkOutput("wrap",   int'(wrap),        mWrap);
   endtask

   task automatic runIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, curDiv, 1'b0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      int budget;
      curDiv = 0;
      applyStimulus(1'b1, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0);

      // Triangle across a full period and a bit
      runIdle(600);

      // ch0 saw, ch1 square, then apply
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 0, 1, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 1, 2, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b1);
      runIdle(520);

      // ch1 triangle offset 256, waits for the wrap; ch0 back to triangle too
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 1, 0, 256, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 0, 0, 0, 1'b0);
      runIdle(1100);

      // Hold ch0, apply immediately, then watch a full period
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 0, 3, 0, 1'b1);
      runIdle(530);
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 0, 0, 0, 1'b1);

      // Prescaler: div=3, then drop 15 -> 2 while the count is 9
      curDiv = 3;
      runIdle(300);
      curDiv = 15;
      budget = 40;
      while (mPresc != 9 && budget > 0) begin
         runIdle(1);
         budget--;
      end
      checkOutput("presc_reach9", (budget > 0) ? 1 : 0, 1);
      curDiv = 2;
      runIdle(20);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, curDiv, 1'b0, 0, 0, 0, 1'b0);
      runIdle(20);

      // Randomized mix of enable, divider, writes, applies and resets
      curDiv = 0;
      for (int i = 0; i < 4000; i++) begin
         bit r, e, we, ap;
         r  = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 9) != 0);
         we = ($urandom_range(0, 24) == 0);
         ap = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 99) == 0) curDiv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
         applyStimulus(r, e, curDiv, we, $urandom_range(0, N_CH - 1),
                       $urandom_range(0, 3), $urandom_range(0, PH_N - 1), ap);
      end

      // Reset mid-ramp with a pending write and apply on the same edge
      curDiv = 0;
      runIdle(50);
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 1, 1, 100, 1'b0);
      applyStimulus(1'b1, 1'b1, 0, 1'b1, 0, 2, 7, 1'b1);
      runIdle(600);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
